axi4_burst_master: RTL and testbench

// - Command-driven AXI4 INCR burst master; sits directly upstream of axi4_full_slave and drives its AW/W/B/AR/R ports.
// - Turns one command (write/read, address, length) into one AXI burst.
// - Write data comes in on a ready/valid stream; read data goes out on one.
// - Pulses done with a status; one command in flight at a time.

---
 rtl/axi4_burst_master.sv | 205 ++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: turns one command (read/write, address, length) into a
// single AXI4 INCR burst. Write data streams in on wr_*, read data streams out
// on rd_*. One command in flight; done/err pulse for one cycle at the end.
module axi4_burst_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   // command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   // write-data stream in
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   // read-data stream out
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   // completion
   output logic                  done,
   output logic                  err,
   // AXI write address
   output logic [ADDR_WIDTH-1:0] AWADDR,
   output logic [7:0]            AWLEN,
   output logic [2:0]            AWSIZE,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   // AXI write data
   output logic [DATA_WIDTH-1:0] WDATA,
   output logic                  WVALID,
   output logic                  WLAST,
   input  logic                  WREADY,
   // AXI write response
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY,
   // AXI read address
   output logic [ADDR_WIDTH-1:0] ARADDR,
   output logic [7:0]            ARLEN,
   output logic [2:0]            ARSIZE,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   // AXI read data
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic                  RVALID,
   input  logic                  RLAST,
   output logic                  RREADY
);

   localparam int         BPB  = DATA_WIDTH / 8;
   localparam logic [2:0] SIZE = 3'($clog2(BPB));

   typedef enum logic [2:0] {
      S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
   } state_t;

   // command latched at accept, held for the whole burst
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [7:0]            len;
   } cmd_t;

   state_t     state;
   cmd_t       cmd_r;
   logic [7:0] beat_cnt;
   logic       err_r;
   logic       cmd_ready_r, awvalid_r, arvalid_r, bready_r, done_r, err_o;

   logic        in_w, in_r;
   logic        w_hs, r_hs;
   logic        exp_last;
   logic [23:0] span_end;
   logic        reject;

   // end of the burst within its 4KB page; wide enough that it never wraps
   assign span_end = {12'd0, cmd_addr[11:0]}
                   + (({16'd0, cmd_len} + 24'd1) * 24'(BPB));
   assign reject   = (span_end > 24'd4096);

   assign in_w     = (state == S_W);
   assign in_r     = (state == S_R);
   assign exp_last = (beat_cnt == cmd_r.len);

   // W and R channels are straight passthroughs, gated by state so no beat
   // leaks out before the address handshake or after reset
   assign WVALID   = in_w & wr_valid;
   assign wr_ready = in_w & WREADY;
   assign WDATA    = wr_data;
   assign WLAST    = WVALID & exp_last;
   assign w_hs     = WVALID & WREADY;

   assign rd_valid = in_r & RVALID;
   assign RREADY   = in_r & rd_ready;
   assign rd_data  = RDATA;
   assign r_hs     = rd_valid & rd_ready;

   assign AWADDR    = cmd_r.addr;
   assign ARADDR    = cmd_r.addr;
   assign AWLEN     = cmd_r.len;
   assign ARLEN     = cmd_r.len;
   assign AWSIZE    = SIZE;
   assign ARSIZE    = SIZE;
   assign AWVALID   = awvalid_r;
   assign ARVALID   = arvalid_r;
   assign BREADY    = bready_r;
   assign cmd_ready = cmd_ready_r;
   assign done      = done_r;
   assign err       = err_o;

   // burst sequencer: accept, address phase, data phase, response, done pulse
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state       <= S_IDLE;
         cmd_r       <= '0;
         beat_cnt    <= 8'd0;
         err_r       <= 1'b0;
         cmd_ready_r <= 1'b1;
         awvalid_r   <= 1'b0;
         arvalid_r   <= 1'b0;
         bready_r    <= 1'b0;
         done_r      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         done_r <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready_r) begin
                  cmd_r.addr  <= cmd_addr;
                  cmd_r.len   <= cmd_len;
                  beat_cnt    <= 8'd0;
                  err_r       <= 1'b0;
                  cmd_ready_r <= 1'b0;
                  if (reject) begin
                     // page-crossing burst: no bus traffic, fail immediately
                     done_r <= 1'b1;
                     err_o  <= 1'b1;
                     state  <= S_DONE;
                  end else if (cmd_write) begin
                     awvalid_r <= 1'b1;
                     state     <= S_AW;
                  end else begin
                     arvalid_r <= 1'b1;
                     state     <= S_AR;
                  end
               end
            end
            S_AW: begin
               if (AWREADY) begin
                  awvalid_r <= 1'b0;
                  state     <= S_W;
               end
            end
            S_W: begin
               if (w_hs) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (exp_last) begin
                     bready_r <= 1'b1;
                     state    <= S_B;
                  end
               end
            end
            S_B: begin
               if (BVALID) begin
                  bready_r <= 1'b0;
                  done_r   <= 1'b1;
                  err_o    <= |BRESP;
                  state    <= S_DONE;
               end
            end
            S_AR: begin
               if (ARREADY) begin
                  arvalid_r <= 1'b0;
                  state     <= S_R;
               end
            end
            S_R: begin
               if (r_hs) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (RLAST != exp_last)
                     err_r <= 1'b1;
                  // the slave's RLAST ends the burst even if it came early
                  if (RLAST) begin
                     done_r <= 1'b1;
                     err_o  <= err_r | (RLAST != exp_last);
                     state  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // done is high this cycle; reopen the command port after it
               cmd_ready_r <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master with a behavioural AXI slave.
module tb_axi4_burst_master;

   logic        ACLK, ARESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid, rd_ready;
   logic [31:0] rd_data;
   logic        done, err;
   logic [31:0] AWADDR;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic        AWVALID, AWREADY;
   logic [31:0] WDATA;
   logic        WVALID, WLAST, WREADY;
   logic [1:0]  BRESP;
   logic        BVALID, BREADY;
   logic [31:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic        ARVALID, ARREADY;
   logic [31:0] RDATA;
   logic        RVALID, RLAST, RREADY;

   axi4_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .done(done), .err(err),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   int n_vec = 0;
   int n_err = 0;

   // slave model state and observation counters
   logic [31:0] mem [1024];
   logic [1:0]  cfg_bresp = 2'b00;
   int          cfg_rlast_beat = -1;
   int          aw_cnt, ar_cnt, w_beats, wlast_cnt, wlast_beat;
   logic [31:0] s_waddr, s_raddr;
   int          s_wlen, s_rlen, s_wbeat, s_rbeat;
   bit          b_pend, r_act;

   // per-command results
   bit          t_done, t_err;
   int          t_acc_cyc, t_done_cyc;
   logic [31:0] rdq [$];

   // AXI slave: samples at negedge, drives just after posedge
   initial begin
      AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
      BVALID = 1'b0; BRESP = 2'b00; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0;
      b_pend = 0; r_act = 0; s_wbeat = 0; s_rbeat = 0; s_wlen = 0; s_rlen = 0;
      s_waddr = '0; s_raddr = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            b_pend = 0; r_act = 0;
         end else begin
            if (AWVALID && AWREADY) begin
               s_waddr = AWADDR; s_wlen = int'(AWLEN); s_wbeat = 0; aw_cnt++;
            end
            if (WVALID && WREADY) begin
               mem[(int'(s_waddr >> 2) + s_wbeat) % 1024] = WDATA;
               if (WLAST) begin
                  wlast_cnt++; wlast_beat = s_wbeat; b_pend = 1;
               end
               s_wbeat++; w_beats++;
            end
            if (BVALID && BREADY) b_pend = 0;
            if (ARVALID && ARREADY) begin
               s_raddr = ARADDR; s_rlen = int'(ARLEN); s_rbeat = 0; r_act = 1; ar_cnt++;
            end
            if (RVALID && RREADY) begin
               if (RLAST) r_act = 0;
               s_rbeat++;
            end
         end
         @(posedge ACLK); #1;
         BVALID = b_pend;
         BRESP  = cfg_bresp;
         RVALID = r_act;
         RDATA  = r_act ? mem[(int'(s_raddr >> 2) + s_rbeat) % 1024] : 32'd0;
         RLAST  = r_act && (s_rbeat == s_rlen || s_rbeat == cfg_rlast_beat);
      end
   end

   // issue one command, feed/drain the streams, stop at done or on budget
   task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                         input bit toggle, input logic [31:0] base);
      int cyc, idx;
      bit acc, whs;
      rdq.delete();
      t_done = 0; t_err = 0; t_acc_cyc = -1; t_done_cyc = -1;
      aw_cnt = 0; ar_cnt = 0; w_beats = 0; wlast_cnt = 0; wlast_beat = -1;
      @(posedge ACLK); #1;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      wr_valid = wr; wr_data = base; idx = 0; rd_ready = 1'b1; cyc = 0;
      while (!t_done && cyc < 3000) begin
         @(negedge ACLK);
         acc = cmd_valid && cmd_ready;
         whs = wr_valid && wr_ready;
         if (acc) t_acc_cyc = cyc;
         if (rd_valid && rd_ready) rdq.push_back(rd_data);
         if (done) begin t_done = 1; t_err = err; t_done_cyc = cyc; end
         @(posedge ACLK); #1;
         if (acc) cmd_valid = 1'b0;
         if (whs) begin
            idx++;
            wr_data = base + 32'(idx);
            if (idx > int'(len)) wr_valid = 1'b0;
         end
         if (toggle) rd_ready = !rd_ready;
         cyc++;
      end
      cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [11:0] got, exp;
      @(negedge ACLK);
      got = {cmd_ready, AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY,
             rd_valid, wr_ready, done, err, 1'b0};
      exp = 12'b1000_0000_0000;
      n_vec++;
      if (got !== exp) begin
         n_err++; $display("FAIL reset_outputs got %b exp %b", got, exp);
      end
      n_vec++;
      if (AWSIZE !== 3'd2 || ARSIZE !== 3'd2) begin
         n_err++; $display("FAIL reset_size got %0d/%0d exp 2/2", AWSIZE, ARSIZE);
      end
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(negedge ACLK);
      n_vec++;
      if (cmd_ready !== 1'b1 || done !== 1'b0 || AWVALID !== 1'b0) begin
         n_err++; $display("FAIL post_reset got rdy=%b done=%b awv=%b exp 1 0 0", cmd_ready, done, AWVALID);
      end
   endtask

   task automatic test_write4();
      do_cmd(1'b1, 32'h100, 8'd3, 1'b0, 32'hA0);
      n_vec++;
      if (t_done !== 1'b1 || t_err !== 1'b0) begin
         n_err++; $display("FAIL wr4_status got done=%b err=%b exp 1 0", t_done, t_err);
      end
      n_vec++;
      if (w_beats !== 4 || wlast_cnt !== 1 || wlast_beat !== 3) begin
         n_err++; $display("FAIL wr4_beats got beats=%0d lasts=%0d at=%0d exp 4 1 3", w_beats, wlast_cnt, wlast_beat);
      end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (mem[32'h40 + i] !== 32'hA0 + 32'(i)) begin
            n_err++; $display("FAIL wr4_mem[%0d] got %h exp %h", i, mem[32'h40 + i], 32'hA0 + 32'(i));
         end
      end
      @(negedge ACLK);
      n_vec++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL wr4_after got done=%b rdy=%b exp 0 1", done, cmd_ready);
      end
   endtask

   task automatic test_read4();
      do_cmd(1'b0, 32'h100, 8'd3, 1'b0, 32'h0);
      n_vec++;
      if (t_done !== 1'b1 || t_err !== 1'b0 || rdq.size() !== 4) begin
         n_err++; $display("FAIL rd4_status got done=%b err=%b n=%0d exp 1 0 4", t_done, t_err, rdq.size());
      end
      for (int i = 0; i < 4 && i < rdq.size(); i++) begin
         n_vec++;
         if (rdq[i] !== 32'hA0 + 32'(i)) begin
            n_err++; $display("FAIL rd4_data[%0d] got %h exp %h", i, rdq[i], 32'hA0 + 32'(i));
         end
      end
   endtask

   task automatic test_read8_toggle();
      logic [31:0] exp;
      do_cmd(1'b0, 32'h100, 8'd7, 1'b1, 32'h0);
      n_vec++;
      if (t_done !== 1'b1 || t_err !== 1'b0 || rdq.size() !== 8) begin
         n_err++; $display("FAIL rd8_status got done=%b err=%b n=%0d exp 1 0 8", t_done, t_err, rdq.size());
      end
      for (int i = 0; i < 8 && i < rdq.size(); i++) begin
         exp = (i < 4) ? 32'hA0 + 32'(i) : 32'h1000_0040 + 32'(i);
         n_vec++;
         if (rdq[i] !== exp) begin
            n_err++; $display("FAIL rd8_data[%0d] got %h exp %h", i, rdq[i], exp);
         end
      end
   endtask

   task automatic test_4kb_edge();
      // exactly reaching the page end is legal
      do_cmd(1'b1, 32'hFFC, 8'd0, 1'b0, 32'h55);
      n_vec++;
      if (t_done !== 1'b1 || t_err !== 1'b0 || aw_cnt !== 1 || w_beats !== 1 || wlast_cnt !== 1) begin
         n_err++; $display("FAIL edge_ok got done=%b err=%b aw=%0d beats=%0d lasts=%0d exp 1 0 1 1 1",
                           t_done, t_err, aw_cnt, w_beats, wlast_cnt);
      end
      n_vec++;
      if (mem[1023] !== 32'h55) begin
         n_err++; $display("FAIL edge_mem got %h exp 00000055", mem[1023]);
      end
      // one beat further crosses the page
      do_cmd(1'b1, 32'hFFC, 8'd1, 1'b0, 32'h66);
      n_vec++;
      if (t_done !== 1'b1 || t_err !== 1'b1 || aw_cnt !== 0 || w_beats !== 0) begin
         n_err++; $display("FAIL reject got done=%b err=%b aw=%0d beats=%0d exp 1 1 0 0", t_done, t_err, aw_cnt, w_beats);
      end
      n_vec++;
      if (t_done_cyc !== t_acc_cyc + 1) begin
         n_err++; $display("FAIL reject_timing got done@%0d acc@%0d exp done one after", t_done_cyc, t_acc_cyc);
      end
   endtask

   task automatic test_write256();
      do_cmd(1'b1, 32'h800, 8'd255, 1'b0, 32'h200);
      n_vec++;
      if (t_done !== 1'b1 || t_err !== 1'b0) begin
         n_err++; $display("FAIL wr256_status got done=%b err=%b exp 1 0", t_done, t_err);
      end
      n_vec++;
      if (w_beats !== 256 || wlast_cnt !== 1 || wlast_beat !== 255) begin
         n_err++; $display("FAIL wr256_beats got beats=%0d lasts=%0d at=%0d exp 256 1 255", w_beats, wlast_cnt, wlast_beat);
      end
      n_vec++;
      if (mem[32'h200] !== 32'h200 || mem[32'h2FF] !== 32'h2FF) begin
         n_err++; $display("FAIL wr256_mem got %h %h exp 00000200 000002ff", mem[32'h200], mem[32'h2FF]);
      end
   endtask

   task automatic test_bresp_err();
      cfg_bresp = 2'b10;
      do_cmd(1'b1, 32'h200, 8'd1, 1'b0, 32'h77);
      cfg_bresp = 2'b00;
      n_vec++;
      if (t_done !== 1'b1 || t_err !== 1'b1) begin
         n_err++; $display("FAIL bresp_err got done=%b err=%b exp 1 1", t_done, t_err);
      end
   endtask

   task automatic test_rlast_mismatch();
      cfg_rlast_beat = 1;
      do_cmd(1'b0, 32'h100, 8'd3, 1'b0, 32'h0);
      cfg_rlast_beat = -1;
      n_vec++;
      if (t_done !== 1'b1 || t_err !== 1'b1 || rdq.size() !== 2) begin
         n_err++; $display("FAIL rlast_early got done=%b err=%b n=%0d exp 1 1 2", t_done, t_err, rdq.size());
      end
      // a clean read afterwards must not inherit the error
      do_cmd(1'b0, 32'h100, 8'd0, 1'b0, 32'h0);
      n_vec++;
      if (t_done !== 1'b1 || t_err !== 1'b0 || rdq.size() !== 1 || rdq[0] !== 32'hA0) begin
         n_err++; $display("FAIL rd_after_err got done=%b err=%b n=%0d exp 1 0 1", t_done, t_err, rdq.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      int cyc;
      bit acc, whs, saw_done;
      aw_cnt = 0; w_beats = 0; saw_done = 0;
      @(posedge ACLK); #1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_len = 8'd7;
      wr_valid = 1'b1; wr_data = 32'hD0; cyc = 0;
      while (w_beats < 2 && cyc < 50) begin
         @(negedge ACLK);
         acc = cmd_valid && cmd_ready;
         whs = wr_valid && wr_ready;
         @(posedge ACLK); #1;
         if (acc) cmd_valid = 1'b0;
         if (whs) wr_data = wr_data + 32'd1;
         cyc++;
      end
      n_vec++;
      if (w_beats < 2) begin
         n_err++; $display("FAIL rst_mid_setup got beats=%0d exp >=2 within 50 cycles", w_beats);
      end
      @(negedge ACLK); #2;
      ARESET = 1'b1;
      #1;
      n_vec++;
      if (AWVALID !== 1'b0 || WVALID !== 1'b0 || BREADY !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_async got awv=%b wv=%b br=%b done=%b exp 0 0 0 0", AWVALID, WVALID, BREADY, done);
      end
      @(posedge ACLK); #1;
      cmd_valid = 1'b0; wr_valid = 1'b0;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         if (done) saw_done = 1;
      end
      n_vec++;
      if (cmd_ready !== 1'b1 || saw_done !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_release got rdy=%b done_seen=%b exp 1 0", cmd_ready, saw_done);
      end
      do_cmd(1'b1, 32'h400, 8'd3, 1'b0, 32'hC0);
      n_vec++;
      if (t_done !== 1'b1 || t_err !== 1'b0 || w_beats !== 4 || mem[32'h103] !== 32'hC3) begin
         n_err++; $display("FAIL rst_mid_next got done=%b err=%b beats=%0d mem=%h exp 1 0 4 000000c3",
                           t_done, t_err, w_beats, mem[32'h103]);
      end
   endtask

   initial begin
      ARESET = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      aw_cnt = 0; ar_cnt = 0; w_beats = 0; wlast_cnt = 0; wlast_beat = -1;
      repeat (3) @(posedge ACLK);
      test_reset();
      test_write4();
      test_read4();
      test_read8_toggle();
      test_4kb_edge();
      test_write256();
      test_bresp_err();
      test_rlast_mismatch();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
